pc_fetch_ctl: RTL and testbench
===============================

Name: pc_fetch_ctl

Overview:
- Program-counter and fetch-sequencing stage that consumes the branch-target lookup table.
- Drives the 4-bit table index from the instruction's branch field and receives the 10-bit Target back.
- Computes the next PC (sequential, absolute jump or relative branch) and runs a start/halt handshake with the testbench.
- Sits between the instruction decoder and the instruction ROM address port.

Parameters:
- PC_W, 10, program counter / Target width in bits.
- LUT_AW, 4, lookup-table index width.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level request from the testbench; program launches on its falling edge.
- Halt  in  1  decoded halt instruction present in the current cycle.
- Branch  in  1  decoded branch/jump instruction present in the current cycle.
- CondTrue  in  1  branch condition flag (tie high for unconditional jumps).
- BranchAbs  in  1  1 = Target is an absolute address; 0 = Target is a signed PC-relative offset.
- LutIdx  in  LUT_AW  branch-target index field from the instruction.
- LutAddr  out  LUT_AW  index to the lookup table; combinational copy of LutIdx.
- Target  in  PC_W  lookup-table result, combinational, same cycle as LutAddr.
- PC  out  PC_W  current instruction address.
- Fetch  out  1  instruction at PC is live and its effects may commit.
- Done  out  1  program has halted.
- CycleCnt  out  CNT_W  number of RUN cycles executed in the current or last program.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, PC=0, Fetch=0, Done=0, CycleCnt=0. Reset overrides all other inputs in the same cycle, including mid-RUN.
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - Start=1 -> ARMED.
  - Outputs: Fetch=0, Done=0.
- ARMED:
  - PC held at 0; CycleCnt cleared to 0; Fetch=0; Done=0.
  - Start=0 -> RUN. The first Fetch=1 cycle follows the falling edge of Start, with PC=0.
- RUN:
  - Fetch=1 every cycle; CycleCnt increments every RUN cycle, including the Halt cycle, and saturates at all-ones (no wrap).
  - Next-PC priority, highest first:
    1. Halt=1 -> state DONE, PC holds.
    2. Branch & CondTrue & BranchAbs -> PC = Target.
    3. Branch & CondTrue & ~BranchAbs -> PC = PC + Target, Target treated as PC_W-bit two's complement, result modulo 2^PC_W.
    4. Otherwise -> PC = PC + 1, wrapping from 1023 to 0.
  - Branch with CondTrue=0 behaves as case 4.
  - Start is ignored in RUN.
- DONE:
  - Done=1 and Fetch=0; PC and CycleCnt hold their last values.
  - Start=1 -> ARMED; Done drops in the first ARMED cycle.
- Latency:
  - PC updates one cycle after the controlling instruction is presented.
  - LutAddr->Target->next-PC is a single-cycle combinational path; no extra pipeline bubble on taken branches.
- Halt and Branch in the same cycle: Halt wins and the branch is discarded.
- Inputs other than Start and Reset are don't-care outside RUN.

Decomposition:
- Shared package pc_pkg contains:
  - state enum {IDLE, ARMED, RUN, DONE};
  - localparams PC_W=10, LUT_AW=4, CNT_W=16;
  - next-PC select enum {NPC_HOLD, NPC_ABS, NPC_REL, NPC_INC}.
- No sub-module. The lookup table stays a separate instance, wired LutAddr->Addr and Target->Target at the top level.
- Next-PC selection is a single always_comb; state, PC and CycleCnt live in a single always_ff.

Test Plan:
- Reset, then raise Start for 3 cycles and drop it -> first Fetch=1 cycle has PC=0. With no branches, PC reads 0,1,2,3 on consecutive cycles and CycleCnt=4 after the 4th RUN cycle.
- In RUN at PC=5, Branch=1, CondTrue=1, BranchAbs=1, LUT returns 336 -> next PC=336. Repeat with CondTrue=0 -> next PC=6.
- Relative branches:
  - PC=20, BranchAbs=0, Target=10'h3FB (-5) -> next PC=15.
  - PC=1020, Target=8 -> next PC=4 (wrap).
- At PC=9 present Halt=1 together with Branch=1, CondTrue=1 -> Done=1 next cycle, PC stays 9, Fetch=0, CycleCnt frozen at 10.
- From DONE, pulse Start for 2 cycles -> Done clears, CycleCnt=0, restart at PC=0. Assert Reset mid-RUN at PC=37 -> next cycle IDLE, PC=0, Fetch=0, CycleCnt=0.
- Force CycleCnt near saturation (CNT_W=4 override, 20 RUN cycles) -> CycleCnt sticks at 15.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and widths for the PC fetch controller
package pc_pkg;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  typedef enum logic [1:0] {NPC_HOLD, NPC_ABS, NPC_REL, NPC_INC} npc_sel_t;

endpackage

// File: rtl/pc_fetch_ctl_if.sv
// rtl/pc_fetch_ctl_if.sv - decoder, lookup-table and ROM-address signals of the fetch controller
interface pc_fetch_ctl_if #(
  parameter int PC_W   = pc_pkg::PC_W,
  parameter int LUT_AW = pc_pkg::LUT_AW,
  parameter int CNT_W  = pc_pkg::CNT_W
);

  logic              Start;
  logic              Halt;
  logic              Branch;
  logic              CondTrue;
  logic              BranchAbs;
  logic [LUT_AW-1:0] LutIdx;
  logic [LUT_AW-1:0] LutAddr;
  logic [PC_W-1:0]   Target;
  logic [PC_W-1:0]   PC;
  logic              Fetch;
  logic              Done;
  logic [CNT_W-1:0]  CycleCnt;

  modport master (
    input  Start, Halt, Branch, CondTrue, BranchAbs, LutIdx, Target,
    output LutAddr, PC, Fetch, Done, CycleCnt
  );

  modport slave (
    output Start, Halt, Branch, CondTrue, BranchAbs, LutIdx, Target,
    input  LutAddr, PC, Fetch, Done, CycleCnt
  );

endinterface

// File: rtl/pc_fetch_ctl.sv
// rtl/pc_fetch_ctl.sv - program counter and start/run/halt fetch sequencer
module pc_fetch_ctl #(
  parameter int PC_W   = pc_pkg::PC_W,
  parameter int LUT_AW = pc_pkg::LUT_AW,
  parameter int CNT_W  = pc_pkg::CNT_W
) (
  input  logic            Clk,
  input  logic            Reset,
  pc_fetch_ctl_if.master  bus
);

  import pc_pkg::*;

  state_t           state, state_nx;
  npc_sel_t         npc_sel;
  logic [PC_W-1:0]  pc, pc_nx;
  logic [CNT_W-1:0] cnt;
  logic             fetch, done;

  assign bus.LutAddr  = bus.LutIdx;
  assign bus.PC       = pc;
  assign bus.CycleCnt = cnt;
  assign bus.Fetch    = fetch;
  assign bus.Done     = done;

  always_comb begin
    state_nx = state;
    npc_sel  = NPC_HOLD;
    fetch    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (bus.Start) state_nx = ARMED;
      ARMED: if (!bus.Start) state_nx = RUN;
      RUN: begin
        fetch = 1'b1;
        // Halt outranks any branch decoded in the same instruction
        if (bus.Halt)
          state_nx = DONE;
        else if (bus.Branch && bus.CondTrue)
          npc_sel = bus.BranchAbs ? NPC_ABS : NPC_REL;
        else
          npc_sel = NPC_INC;
      end
      DONE: begin
        done = 1'b1;
        if (bus.Start) state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase

    case (npc_sel)
      NPC_ABS: pc_nx = bus.Target;
      NPC_REL: pc_nx = pc + bus.Target;
      NPC_INC: pc_nx = pc + PC_W'(1);
      default: pc_nx = pc;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      // every path into ARMED starts a fresh program at address 0
      if (state_nx == ARMED) begin
        pc  <= '0;
        cnt <= '0;
      end else begin
        pc <= pc_nx;
        if (state == RUN && cnt != '1)
          cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// tb/tb_pc_fetch_ctl.sv - directed bench for pc_fetch_ctl
module tb_pc_fetch_ctl;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctl_if                  ia ();
  pc_fetch_ctl_if #(.CNT_W(4))     ib ();

  pc_fetch_ctl u_dut (
    .Clk   (clk),
    .Reset (rst_a),
    .bus   (ia)
  );

  pc_fetch_ctl #(.CNT_W(4)) u_dut_sat (
    .Clk   (clk),
    .Reset (rst_b),
    .bus   (ib)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic abs, input logic cond, input logic [9:0] tgt);
    ia.Branch    = 1'b1;
    ia.CondTrue  = cond;
    ia.BranchAbs = abs;
    ia.Target    = tgt;
    tick();
    ia.Branch    = 1'b0;
    ia.CondTrue  = 1'b0;
    ia.BranchAbs = 1'b0;
    ia.Target    = '0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.Start = 0; ia.Halt = 0; ia.Branch = 0; ia.CondTrue = 0; ia.BranchAbs = 0;
    ia.LutIdx = '0; ia.Target = '0;
    ib.Start = 0; ib.Halt = 0; ib.Branch = 0; ib.CondTrue = 0; ib.BranchAbs = 0;
    ib.LutIdx = '0; ib.Target = '0;
    tick(); tick();
    chk("rst_pc", 32'(ia.PC), 0);
    chk("rst_fetch", 32'(ia.Fetch), 0);
    chk("rst_done", 32'(ia.Done), 0);
    chk("rst_cnt", 32'(ia.CycleCnt), 0);

    rst_a = 1'b0;
    tick();
    chk("idle_fetch", 32'(ia.Fetch), 0);

    ia.Start = 1'b1;
    tick(); tick(); tick();
    chk("armed_fetch", 32'(ia.Fetch), 0);
    ia.Start = 1'b0;
    tick();
    chk("first_fetch", 32'(ia.Fetch), 1);
    chk("first_pc", 32'(ia.PC), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", 32'(ia.PC), 32'(i));
    end
    tick();
    chk("cnt4", 32'(ia.CycleCnt), 4);

    repeat (5) tick();
    chk("pc9", 32'(ia.PC), 9);
    ia.Halt = 1'b1; ia.Branch = 1'b1; ia.CondTrue = 1'b1; ia.BranchAbs = 1'b1; ia.Target = 10'd336;
    tick();
    ia.Halt = 1'b0; ia.Branch = 1'b0; ia.CondTrue = 1'b0; ia.BranchAbs = 1'b0; ia.Target = '0;
    chk("halt_done", 32'(ia.Done), 1);
    chk("halt_pc", 32'(ia.PC), 9);
    chk("halt_fetch", 32'(ia.Fetch), 0);
    chk("halt_cnt", 32'(ia.CycleCnt), 10);
    tick();
    chk("done_cnt_hold", 32'(ia.CycleCnt), 10);
    chk("done_pc_hold", 32'(ia.PC), 9);

    ia.Start = 1'b1;
    tick();
    chk("rearm_done", 32'(ia.Done), 0);
    chk("rearm_cnt", 32'(ia.CycleCnt), 0);
    tick();
    ia.Start = 1'b0;
    tick();
    chk("restart_fetch", 32'(ia.Fetch), 1);
    chk("restart_pc", 32'(ia.PC), 0);

    repeat (5) tick();
    ia.LutIdx = 4'hA;
    #1;
    chk("lutaddr", 32'(ia.LutAddr), 10);
    br(1'b1, 1'b1, 10'd336);
    chk("abs_taken", 32'(ia.PC), 336);
    br(1'b1, 1'b1, 10'd5);
    br(1'b1, 1'b0, 10'd336);
    chk("abs_not_taken", 32'(ia.PC), 6);
    br(1'b1, 1'b1, 10'd20);
    br(1'b0, 1'b1, 10'h3FB);
    chk("rel_neg", 32'(ia.PC), 15);
    br(1'b1, 1'b1, 10'd1020);
    br(1'b0, 1'b1, 10'd8);
    chk("rel_wrap", 32'(ia.PC), 4);
    ia.Start = 1'b1;
    tick();
    ia.Start = 1'b0;
    chk("start_in_run_pc", 32'(ia.PC), 5);
    chk("start_in_run_fetch", 32'(ia.Fetch), 1);
    br(1'b1, 1'b1, 10'd37);
    chk("pc37", 32'(ia.PC), 37);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("midrun_rst_fetch", 32'(ia.Fetch), 0);
    chk("midrun_rst_pc", 32'(ia.PC), 0);
    chk("midrun_rst_cnt", 32'(ia.CycleCnt), 0);

    rst_b = 1'b0;
    ib.Start = 1'b1;
    tick();
    ib.Start = 1'b0;
    tick();
    repeat (15) tick();
    chk("sat_reach", 32'(ib.CycleCnt), 15);
    repeat (5) tick();
    chk("sat_stick", 32'(ib.CycleCnt), 15);
    chk("sat_pc", 32'(ib.PC), 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
